// File: rtl/mcu_io_hub.sv
`default_nettype none
// ============================================================================
// Module : mcu_io_hub
// Brief  : Port-bus I/O hub: latched output channels, registered input mux,
//          and an edge-triggered maskable interrupt aggregator.
// Rev    : 1.0  initial release
// ============================================================================
module mcu_io_hub #(
    parameter int              DATA_W      = 8,
    parameter int              ID_W        = 8,
    parameter int              N_OUT       = 4,
    parameter int              N_IN        = 4,
    parameter int              N_IRQ       = 4,
    parameter logic [ID_W-1:0] OUT_BASE    = 8'h40,
    parameter logic [ID_W-1:0] IN_BASE     = 8'h20,
    parameter logic [ID_W-1:0] INT_STAT_ID = 8'hF0,
    parameter logic [ID_W-1:0] INT_MASK_ID = 8'hF1
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic [ID_W-1:0]         PORT_ID,
    input  logic [DATA_W-1:0]       OUT_PORT,
    input  logic                    IO_STRB,
    output logic [DATA_W-1:0]       IN_PORT,
    input  logic [N_IN*DATA_W-1:0]  IN_DATA,
    output logic [N_OUT*DATA_W-1:0] OUT_DATA,
    output logic [N_OUT-1:0]        OUT_VALID,
    input  logic [N_IRQ-1:0]        IRQ,
    output logic                    INTR
);

    localparam int c_OUT_LO = int'(OUT_BASE);
    localparam int c_IN_LO  = int'(IN_BASE);
    localparam int c_STAT   = int'(INT_STAT_ID);
    localparam int c_MASK   = int'(INT_MASK_ID);
    localparam int c_ID_SPAN = 1 << ID_W;

    localparam bit c_BAD_SIZE = (N_OUT < 1) || (N_OUT > 16) || (N_IN < 1) || (N_IN > 16) ||
                                (N_IRQ < 1) || (N_IRQ >= DATA_W);
    localparam bit c_BAD_SPAN = (c_OUT_LO + N_OUT > c_ID_SPAN) || (c_IN_LO + N_IN > c_ID_SPAN);
    localparam bit c_BAD_OVL  = ((c_OUT_LO < c_IN_LO + N_IN) && (c_IN_LO < c_OUT_LO + N_OUT)) ||
                                ((c_STAT >= c_OUT_LO) && (c_STAT < c_OUT_LO + N_OUT)) ||
                                ((c_STAT >= c_IN_LO)  && (c_STAT < c_IN_LO + N_IN))   ||
                                ((c_MASK >= c_OUT_LO) && (c_MASK < c_OUT_LO + N_OUT)) ||
                                ((c_MASK >= c_IN_LO)  && (c_MASK < c_IN_LO + N_IN))   ||
                                (c_STAT == c_MASK);

    generate
        if (c_BAD_SIZE || c_BAD_SPAN || c_BAD_OVL) begin : g_cfg_err
            $error("mcu_io_hub: invalid parameter configuration");
        end
    endgenerate

    logic [N_OUT-1:0]        w_out_wr;
    logic [N_OUT*DATA_W-1:0] r_out_data;
    logic [N_OUT-1:0]        r_out_valid;
    logic [N_IN*DATA_W-1:0]  r_in_q;

    logic [N_IRQ-1:0] r_s1, r_s2, r_prv, r_pend, r_mask;
    logic [1:0]       r_sync_ok;
    logic             r_ovf, r_intr;
    logic [N_IRQ-1:0] w_edge, w_clr, w_pend_nxt;
    logic             w_stat_wr, w_mask_wr, w_ovf_clr;
    logic [DATA_W-1:0] w_stat_rd, w_mask_rd, w_rd;

    always_comb begin
        for (int k = 0; k < N_OUT; k++) begin
            w_out_wr[k] = IO_STRB && (PORT_ID == ID_W'(c_OUT_LO + k));
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_out_data  <= '0;
            r_out_valid <= '0;
            r_in_q      <= '0;
        end else begin
            r_out_valid <= w_out_wr;
            r_in_q      <= IN_DATA;
            for (int k = 0; k < N_OUT; k++) begin
                if (w_out_wr[k]) begin
                    r_out_data[k*DATA_W +: DATA_W] <= OUT_PORT;
                end
            end
        end
    end

    assign w_stat_wr  = IO_STRB && (PORT_ID == INT_STAT_ID);
    assign w_mask_wr  = IO_STRB && (PORT_ID == INT_MASK_ID);
    assign w_clr      = w_stat_wr ? OUT_PORT[N_IRQ-1:0] : '0;
    assign w_ovf_clr  = w_stat_wr && OUT_PORT[DATA_W-1];
    assign w_edge     = r_s2 & ~r_prv;
    assign w_pend_nxt = (r_pend & ~w_clr) | w_edge;

    // prv keeps its all-ones reset value until s2 carries a genuinely sampled
    // value, so a line held high across reset release never looks like an edge.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_s1      <= '0;
            r_s2      <= '0;
            r_prv     <= '1;
            r_sync_ok <= 2'b00;
            r_pend    <= '0;
            r_mask    <= '0;
            r_ovf     <= 1'b0;
            r_intr    <= 1'b0;
        end else begin
            r_s1      <= IRQ;
            r_s2      <= r_s1;
            r_sync_ok <= {r_sync_ok[0], 1'b1};
            if (r_sync_ok[1]) begin
                r_prv <= r_s2;
            end
            r_pend <= w_pend_nxt;
            if (|(w_edge & r_pend)) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
            if (w_mask_wr) begin
                r_mask <= OUT_PORT[N_IRQ-1:0];
            end
            r_intr <= |(r_pend & r_mask);
        end
    end

    always_comb begin
        w_stat_rd              = '0;
        w_stat_rd[N_IRQ-1:0]   = r_pend;
        w_stat_rd[DATA_W-1]    = r_ovf;
        w_mask_rd              = '0;
        w_mask_rd[N_IRQ-1:0]   = r_mask;
        w_rd                   = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (PORT_ID == ID_W'(c_IN_LO + k)) begin
                w_rd = r_in_q[k*DATA_W +: DATA_W];
            end
        end
        if (PORT_ID == INT_STAT_ID) begin
            w_rd = w_stat_rd;
        end else if (PORT_ID == INT_MASK_ID) begin
            w_rd = w_mask_rd;
        end
    end

    assign IN_PORT   = w_rd;
    assign OUT_DATA  = r_out_data;
    assign OUT_VALID = r_out_valid;
    assign INTR      = r_intr;

endmodule
`default_nettype wire

// File: tb/tb_mcu_io_hub.sv
`default_nettype none
// ============================================================================
// Module : tb_mcu_io_hub
// Brief  : Randomised scoreboard bench for mcu_io_hub with a reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mcu_io_hub;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic [7:0]  PORT_ID = 8'h00;
    logic [7:0]  OUT_PORT = 8'h00;
    logic        IO_STRB = 1'b0;
    logic [31:0] IN_DATA = 32'h0;
    logic [3:0]  IRQ = 4'h0;
    logic [7:0]  IN_PORT;
    logic [31:0] OUT_DATA;
    logic [3:0]  OUT_VALID;
    logic        INTR;

    mcu_io_hub dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .PORT_ID   (PORT_ID),
        .OUT_PORT  (OUT_PORT),
        .IO_STRB   (IO_STRB),
        .IN_PORT   (IN_PORT),
        .IN_DATA   (IN_DATA),
        .OUT_DATA  (OUT_DATA),
        .OUT_VALID (OUT_VALID),
        .IRQ       (IRQ),
        .INTR      (INTR)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic        intr;
        logic [7:0]  in_port;
        logic [3:0]  valid;
        logic [31:0] out_data;
    } exp_t;
    exp_t exp_q[$];

    // Reference model state: architectural registers plus the post-reset IRQ sample history.
    logic [7:0] m_out[4];
    logic [7:0] m_inq[4];
    logic [3:0] m_valid, m_mask, m_pend;
    logic       m_ovf, m_intr;
    logic [3:0] samp[$];
    bit         m_known = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sample k (1 = first edge after reset release); anything older counts as high.
    function automatic logic [3:0] samp_at(input int k);
        if (k < 1) return 4'hF;
        return samp[k-1];
    endfunction

    function automatic logic [7:0] model_read(input logic [7:0] id);
        if (id >= 8'h20 && id < 8'h24) return m_inq[id - 8'h20];
        if (id == 8'hF0) return {m_ovf, 3'b000, m_pend};
        if (id == 8'hF1) return {4'h0, m_mask};
        return 8'h00;
    endfunction

    task automatic model_update();
        int         t;
        logic [3:0] e, clr;
        logic       new_intr;
        if (!RESET_N) begin
            for (int k = 0; k < 4; k++) begin
                m_out[k] = 8'h00;
                m_inq[k] = 8'h00;
            end
            m_valid = 4'h0; m_mask = 4'h0; m_pend = 4'h0;
            m_ovf = 1'b0; m_intr = 1'b0;
            samp.delete();
            m_known = 1;
        end else if (m_known) begin
            t        = samp.size() + 1;
            e        = samp_at(t - 2) & ~samp_at(t - 3);
            new_intr = |(m_pend & m_mask);
            clr      = (IO_STRB && PORT_ID == 8'hF0) ? OUT_PORT[3:0] : 4'h0;
            if (|(e & m_pend)) m_ovf = 1'b1;
            else if (IO_STRB && PORT_ID == 8'hF0 && OUT_PORT[7]) m_ovf = 1'b0;
            m_pend = (m_pend & ~clr) | e;
            if (IO_STRB && PORT_ID == 8'hF1) m_mask = OUT_PORT[3:0];
            m_valid = 4'h0;
            if (IO_STRB && PORT_ID >= 8'h40 && PORT_ID < 8'h44) begin
                m_out[PORT_ID - 8'h40]   = OUT_PORT;
                m_valid[PORT_ID - 8'h40] = 1'b1;
            end
            for (int k = 0; k < 4; k++) m_inq[k] = IN_DATA[k*8 +: 8];
            m_intr = new_intr;
            samp.push_back(IRQ);
        end
    endtask

    // One bus cycle: drive inputs, log what the outputs must show now, then clock.
    task automatic cycle(input logic rn, input logic st, input logic [7:0] id, input logic [7:0] d);
        exp_t e;
        RESET_N  = rn;
        IO_STRB  = st;
        PORT_ID  = id;
        OUT_PORT = d;
        if (m_known) begin
            e.intr     = m_intr;
            e.in_port  = model_read(id);
            e.valid    = m_valid;
            e.out_data = {m_out[3], m_out[2], m_out[1], m_out[0]};
            exp_q.push_back(e);
        end
        @(posedge CLK);
        model_update();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic peek(input string name, input logic [7:0] id, input logic [7:0] exp);
        IO_STRB = 1'b0;
        PORT_ID = id;
        #1;
        chk(name, IN_PORT, exp);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_intr", INTR, e.intr);
            chk("sb_in_port", IN_PORT, e.in_port);
            chk("sb_out_valid", OUT_VALID, e.valid);
            chk("sb_out_data", OUT_DATA, e.out_data);
        end
    end

    initial begin
        logic [7:0] ids[10];
        logic [7:0] id;
        ids = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h20, 8'h23, 8'h30, 8'hF0, 8'hF1};
        @(posedge CLK);
        #1;

        // Reset dominates a same-cycle write; IRQ held high across release.
        IRQ = 4'hF;
        IN_DATA = 32'h12345678;
        repeat (3) cycle(1'b0, 1'b1, 8'h40, 8'hAA);
        chk("rst_out_data", OUT_DATA, 32'h0);
        chk("rst_out_valid", OUT_VALID, 4'h0);
        chk("rst_intr", INTR, 1'b0);
        idle(6);
        peek("rst_status", 8'hF0, 8'h00);
        IRQ = 4'h0;
        idle(3);

        // Output channel writes and an unmapped write.
        cycle(1'b1, 1'b1, 8'h42, 8'h5C);
        chk("out_ch2", OUT_DATA[23:16], 8'h5C);
        chk("out_pulse", OUT_VALID, 4'b0100);
        idle(1);
        chk("out_pulse_end", OUT_VALID, 4'h0);
        cycle(1'b1, 1'b1, 8'h44, 8'h11);
        chk("unmapped_valid", OUT_VALID, 4'h0);
        chk("unmapped_data", OUT_DATA, 32'h005C0000);
        cycle(1'b1, 1'b1, 8'h41, 8'h01);
        cycle(1'b1, 1'b1, 8'h41, 8'h02);
        chk("b2b_valid", OUT_VALID, 4'b0010);
        chk("b2b_data", OUT_DATA[15:8], 8'h02);

        // Input mux.
        IN_DATA = 32'h7E000000;
        idle(1);
        peek("in_ch3", 8'h23, 8'h7E);
        peek("in_unmapped", 8'h30, 8'h00);

        // Basic interrupt: latency and W1C deassert.
        cycle(1'b1, 1'b1, 8'hF1, 8'h02);
        IRQ = 4'b0010;
        idle(3);
        chk("irq_early", INTR, 1'b0);
        idle(1);
        chk("irq_rise", INTR, 1'b1);
        IRQ = 4'h0;
        peek("irq_status", 8'hF0, 8'h02);
        cycle(1'b1, 1'b1, 8'hF0, 8'h02);
        idle(1);
        chk("irq_clear", INTR, 1'b0);

        // Masked double edge gives overflow; late unmask raises INTR.
        cycle(1'b1, 1'b1, 8'hF1, 8'h00);
        IRQ = 4'b0001; idle(3);
        IRQ = 4'b0000; idle(3);
        IRQ = 4'b0001; idle(3);
        IRQ = 4'b0000; idle(3);
        chk("masked_intr", INTR, 1'b0);
        peek("ovf_status", 8'hF0, 8'h81);
        cycle(1'b1, 1'b1, 8'hF1, 8'h01);
        idle(1);
        chk("unmask_intr", INTR, 1'b1);
        cycle(1'b1, 1'b1, 8'hF0, 8'h81);
        idle(1);
        peek("w1c_status", 8'hF0, 8'h00);

        // Edge collides with W1C of the same pending bit.
        IRQ = 4'b0100; idle(3);
        IRQ = 4'b0000; idle(3);
        IRQ = 4'b0100;
        idle(2);
        cycle(1'b1, 1'b1, 8'hF0, 8'h04);
        peek("set_wins", 8'hF0, 8'h84);
        IRQ = 4'h0;
        idle(2);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            IN_DATA = $urandom;
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 3) == 0) IRQ[b] = ~IRQ[b];
            end
            id = ($urandom_range(0, 7) == 0) ? 8'($urandom) : ids[$urandom_range(0, 9)];
            cycle(($urandom_range(0, 79) != 0), ($urandom_range(0, 1) == 1), id, 8'($urandom));
        end
        idle(2);

        @(negedge CLK);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mcu_io_hub.md
# mcu_io_hub

Parametrised I/O and interrupt hub on the MCU port bus (PORT_ID / OUT_PORT / IO_STRB / IN_PORT). It provides the following:
- Decodes port IDs into N_OUT latched output registers with per-channel write pulses.
- Registers and multiplexes N_IN input channels onto IN_PORT.
- Aggregates N_IRQ external interrupt lines into one maskable INTR request for the control unit, with edge detection, pending/mask registers and a sticky overflow flag.

It replaces ad-hoc per-board output latches and single-line interrupt wiring.

## Interface
- DATA_W, 8, port data width
- ID_W, 8, PORT_ID width
- N_OUT, 4, number of output channels (1..16)
- N_IN, 4, number of input channels (1..16)
- N_IRQ, 4, number of interrupt lines (1..DATA_W-1)
- OUT_BASE, 8'h40, PORT_ID of output channel 0; channel k at OUT_BASE+k
- IN_BASE, 8'h20, PORT_ID of input channel 0; channel k at IN_BASE+k
- INT_STAT_ID, 8'hF0, PORT_ID of interrupt status register
- INT_MASK_ID, 8'hF1, PORT_ID of interrupt mask register

Ports:
- CLK  in  1  single clock, all state on rising edge
- RESET_N  in  1  synchronous, active-low reset
- PORT_ID  in  ID_W  port address from MCU
- OUT_PORT  in  DATA_W  write data from MCU
- IO_STRB  in  1  write strobe, one cycle per OUT instruction
- IN_PORT  out  DATA_W  read data to MCU, combinational on PORT_ID
- IN_DATA  in  N_IN*DATA_W  external input channels, channel k at [k*DATA_W +: DATA_W]
- OUT_DATA  out  N_OUT*DATA_W  latched output channels, same packing
- OUT_VALID  out  N_OUT  one-cycle pulse per channel write
- IRQ  in  N_IRQ  asynchronous external interrupt lines, rising-edge active
- INTR  out  1  registered interrupt request to control unit

## Operation
- **Output write**
  - Trigger: IO_STRB=1 and OUT_BASE <= PORT_ID < OUT_BASE+N_OUT.
  - Channel k=PORT_ID-OUT_BASE loads OUT_PORT.
  - OUT_VALID[k]=1 for exactly the following cycle.
  - All other channels hold.
- **Mask write**: IO_STRB=1 and PORT_ID=INT_MASK_ID sets mask <= OUT_PORT[N_IRQ-1:0].
- **Status write**: IO_STRB=1 and PORT_ID=INT_STAT_ID is write-1-to-clear.
  - Bits [N_IRQ-1:0] clear pending bits.
  - Bit DATA_W-1 clears overflow.
- **Unmapped writes**: IO_STRB with any other PORT_ID is ignored; no state change, no pulse.
- **Input sampling**: IN_DATA is registered every cycle into in_q; no reset dependence after the first cycle.
- **IN_PORT decode** (combinational, independent of IO_STRB):
  - PORT_ID in the input range returns in_q[k].
  - PORT_ID=INT_STAT_ID returns {overflow, zero pad, pending}.
  - PORT_ID=INT_MASK_ID returns {zero pad, mask}.
  - Any other ID returns 0.
- **Interrupt path**
  - Each IRQ bit passes through a 2-flop synchroniser (s1, s2), then a previous-value flop (prv).
  - A rising edge is s2 & ~prv.
  - On an edge, pending[i] sets.
  - If pending[i] is already 1 at the edge, overflow sets (sticky).
  - Set wins over a simultaneous W1C clear of the same bit; overflow also sets in that case.
  - Masking never clears pending.
  - INTR <= |(pending & mask), registered.
  - Unmasking an already-pending bit raises INTR one cycle after the mask write.
- **Elaboration**: overlapping address ranges, or N_IRQ >= DATA_W, are configuration errors and must fail elaboration.

## Timing
- **Reset** (RESET_N=0 at a rising edge):
  - OUT_DATA=0, OUT_VALID=0, mask=0, pending=0, overflow=0, INTR=0, in_q=0.
  - s1=s2=0, prv=all ones, so a line held high across reset release produces no edge.
- **Reset mid-operation**: reset overrides a same-cycle IO_STRB; the write is lost and OUT_VALID stays 0.
- **Write latency**: with IO_STRB at edge N, OUT_DATA is valid and OUT_VALID is high after edge N, and OUT_VALID drops after N+1.
- **Back-to-back writes** to the same channel on consecutive cycles give OUT_VALID high for two cycles; the last value wins.
- **Input latency**: IN_DATA change before edge N is visible on IN_PORT after edge N.
- **IRQ latency**: with IRQ first sampled high at edge N, s2=1 at N+1, pending at N+2, INTR at N+3.
- **Minimum pulse width**: an IRQ pulse must be ≥2 CLK periods to be guaranteed captured.
- **INTR deassert**: a W1C at edge M that clears the last masked pending bit drops INTR after M+1.

## Test plan
- **Reset**: hold RESET_N=0 with IO_STRB=1, PORT_ID=8'h40, OUT_PORT=8'hAA -> all OUT_DATA=0, OUT_VALID=0, INTR=0; after release IN_PORT at 8'hF0 reads 8'h00.
- **Output channels**: OUT to 8'h42 with 8'h5C -> channel 2=8'h5C and OUT_VALID=4'b0100 for one cycle; OUT to 8'h44 (unmapped) -> no change, no pulse.
- **Input mux**: IN_DATA channel 3=8'h7E -> one cycle later IN_PORT=8'h7E at PORT_ID 8'h23; PORT_ID 8'h30 -> 8'h00.
- **Interrupt basic**: mask=4'b0010, IRQ[1] rises -> INTR high 3 cycles after the first sampling edge; status reads 8'h02; W1C 8'h02 -> INTR low next cycle.
- **Masked/overflow**: IRQ[0] two rising edges with mask=0 -> INTR stays 0 and status reads 8'h81; write mask 8'h01 -> INTR next cycle; W1C 8'h81 -> status 8'h00.
- **Simultaneous set/clear**: W1C of bit 2 in the same cycle as an IRQ[2] edge -> pending[2] remains 1 and overflow=1; IRQ held high through reset release -> no pending.
